mrpnwp_t1_bank_resp: RTL and testbench

- Memory-side responder for the t1 physical interface driven by the multi-port 1R1W algorithm top.
- Behavioural, synthesizable model of NUMVBNK banks, each 1 write port (A) and 1 read port (B), PHYWDTH bits wide, NUMSROW rows deep.
- Accepts group-replicated write/read commands, applies bit-masked writes, returns read data after SRAM_DELAY cycles with optional single-error injection.
- Clears itself after reset, checks replicated command copies, and flags protocol errors.
- Used as the memory behind the top in block-level simulation and formal.

---
 rtl/mrpnwp_t1_pkg.sv | 21 ++
 rtl/mrpnwp_t1_bank.sv | 99 +++++++++
 rtl/mrpnwp_t1_bank_resp.sv | 123 ++++++++++++
 tb/tb_mrpnwp_t1_bank_resp.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mrpnwp_t1_pkg.sv
// Shared types and helpers for the t1 bank responder: FSM encoding and
// copy-major bus slicing used by the replicated command decode.
package mrpnwp_t1_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int MAX_SRAM_DELAY = 8;

  // Lowest bit of the field belonging to (copy, bank) on a copy-major bus.
  function automatic int slice_lo(input int copy, input int bank, input int nbank, input int width);
    return (copy * nbank + bank) * width;
  endfunction

  function automatic logic row_ok(input int row, input int rows);
    return row < rows;
  endfunction

endpackage

// File: rtl/mrpnwp_t1_bank.sv
// One physical bank: bit-masked write port, read port with a STAGES-deep
// return pipeline and optional bit-0 error injection on the returned word.
module mrpnwp_t1_bank
  import mrpnwp_t1_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_clr,
  input  logic [ADDR_W-1:0] init_row,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] bw,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ok,
  input  logic              inj,
  output logic [DATA_W-1:0] dout,
  output logic              serr
);

  if (STAGES < 1 || STAGES > MAX_SRAM_DELAY) begin : g_bad_delay
    $error("mrpnwp_t1_bank: STAGES out of range");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] last_data;
  logic              last_vld;
  logic              last_serr;

  always_ff @(posedge clk) begin
    if (init_clr) begin
      mem[init_row] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= (mem[wr_addr] & ~bw) | (din & bw);
    end
  end

  // Stage p0: array sampled combinationally, so a same-cycle write is not yet visible.
  assign rd_word = (rd_ok ? mem[rd_addr] : '0) ^ DATA_W'(inj);

  if (STAGES == 1) begin : g_direct
    assign last_data = rd_word;
    assign last_vld  = rd_en;
    assign last_serr = rd_en & inj;
  end else begin : g_pipe
    logic [DATA_W-1:0] data_p [STAGES-1];
    logic              vld_p  [STAGES-1];
    logic              serr_p [STAGES-1];

    // Stages p1..p(STAGES-1): data shifts freely, only valid/serr are reset.
    always_ff @(posedge clk) begin
      data_p[0] <= rd_word;
      for (int k = 1; k < STAGES - 1; k++) begin
        data_p[k] <= data_p[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          vld_p[k]  <= 1'b0;
          serr_p[k] <= 1'b0;
        end
      end else begin
        vld_p[0]  <= rd_en;
        serr_p[0] <= rd_en & inj;
        for (int k = 1; k < STAGES - 1; k++) begin
          vld_p[k]  <= vld_p[k-1];
          serr_p[k] <= serr_p[k-1];
        end
      end
    end

    assign last_data = data_p[STAGES-2];
    assign last_vld  = vld_p[STAGES-2];
    assign last_serr = serr_p[STAGES-2];
  end

  // Output stage: dout holds between results, serr pulses with its word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout <= '0;
      serr <= 1'b0;
    end else begin
      serr <= last_vld & last_serr;
      if (last_vld) begin
        dout <= last_data;
      end
    end
  end

endmodule

// File: rtl/mrpnwp_t1_bank_resp.sv
// Memory-side responder for the t1 interface: clears all banks after reset,
// decodes replicated commands from copy 0 and flags copy disagreement / bad rows.
module mrpnwp_t1_bank_resp
  import mrpnwp_t1_pkg::*;
#(
  parameter int NUMVBNK    = 8,
  parameter int BITVBNK    = 3,
  parameter int NUMSROW    = 256,
  parameter int BITSROW    = 8,
  parameter int PHYWDTH    = 128,
  parameter int NUMGRPW    = 14,
  parameter int SRAM_DELAY = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUMGRPW*NUMVBNK-1:0]          t1_writeA,
  input  logic [NUMGRPW*NUMVBNK*BITSROW-1:0]  t1_addrA,
  input  logic [NUMVBNK*PHYWDTH-1:0]          t1_bwA,
  input  logic [NUMVBNK*PHYWDTH-1:0]          t1_dinA,
  input  logic [NUMGRPW*NUMVBNK-1:0]          t1_readB,
  input  logic [NUMGRPW*NUMVBNK*BITSROW-1:0]  t1_addrB,
  input  logic [NUMVBNK-1:0]                  inj_serr,
  output logic [NUMVBNK*PHYWDTH-1:0]          t1_doutB,
  output logic [NUMVBNK-1:0]                  t1_serrB,
  output logic                                ready,
  output logic                                grp_err,
  output logic                                oor_err
);

  if ((1 << BITVBNK) < NUMVBNK) begin : g_bad_bitvbnk
    $error("mrpnwp_t1_bank_resp: BITVBNK too small for NUMVBNK");
  end

  state_t             state;
  logic [BITSROW-1:0] init_cnt;
  logic               running;
  logic               init_clr;
  logic [NUMVBNK-1:0] grp_bank_mis;
  logic [NUMVBNK-1:0] oor_bank;

  assign running  = (state == ST_RUN);
  assign ready    = running;
  assign init_clr = rst && (state == ST_INIT);

  for (genvar b = 0; b < NUMVBNK; b++) begin : g_bank
    localparam int EN0 = slice_lo(0, b, NUMVBNK, 1);
    localparam int AD0 = slice_lo(0, b, NUMVBNK, BITSROW);

    logic               wr_cmd;
    logic               rd_cmd;
    logic [BITSROW-1:0] wr_addr;
    logic [BITSROW-1:0] rd_addr;
    logic               wr_inr;
    logic               rd_inr;
    logic [NUMGRPW-1:0] copy_mis;

    assign wr_cmd  = t1_writeA[EN0];
    assign rd_cmd  = t1_readB[EN0];
    assign wr_addr = t1_addrA[AD0 +: BITSROW];
    assign rd_addr = t1_addrB[AD0 +: BITSROW];
    assign wr_inr  = row_ok(int'(wr_addr), NUMSROW);
    assign rd_inr  = row_ok(int'(rd_addr), NUMSROW);

    // Addresses only matter on copies whose own enable is set.
    assign copy_mis[0] = 1'b0;
    for (genvar g = 1; g < NUMGRPW; g++) begin : g_copy
      localparam int ENG = slice_lo(g, b, NUMVBNK, 1);
      localparam int ADG = slice_lo(g, b, NUMVBNK, BITSROW);
      assign copy_mis[g] = (t1_writeA[ENG] != wr_cmd)
                        || (t1_writeA[ENG] && (t1_addrA[ADG +: BITSROW] != wr_addr))
                        || (t1_readB[ENG] != rd_cmd)
                        || (t1_readB[ENG] && (t1_addrB[ADG +: BITSROW] != rd_addr));
    end

    assign grp_bank_mis[b] = |copy_mis;
    assign oor_bank[b]     = (wr_cmd && !wr_inr) || (rd_cmd && !rd_inr);

    mrpnwp_t1_bank #(
      .DATA_W (PHYWDTH),
      .ADDR_W (BITSROW),
      .DEPTH  (NUMSROW),
      .STAGES (SRAM_DELAY)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .init_clr (init_clr),
      .init_row (init_cnt),
      .wr_en    (running && wr_cmd && wr_inr),
      .wr_addr  (wr_addr),
      .bw       (t1_bwA[b*PHYWDTH +: PHYWDTH]),
      .din      (t1_dinA[b*PHYWDTH +: PHYWDTH]),
      .rd_en    (running && rd_cmd),
      .rd_addr  (rd_addr),
      .rd_ok    (rd_inr),
      .inj      (inj_serr[b]),
      .dout     (t1_doutB[b*PHYWDTH +: PHYWDTH]),
      .serr     (t1_serrB[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      grp_err  <= 1'b0;
      oor_err  <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + BITSROW'(1);
        if (init_cnt == BITSROW'(NUMSROW - 1)) begin
          state <= ST_RUN;
        end
      end
      if (running && (|grp_bank_mis)) begin
        grp_err <= 1'b1;
      end
      if (running && (|oor_bank)) begin
        oor_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mrpnwp_t1_bank_resp.sv
// Directed bench for the t1 bank responder: init sweep, masked writes,
// read-before-write, error injection, replicated-copy mismatch and mid-burst reset.
module tb_mrpnwp_t1_bank_resp;

  localparam int NUMVBNK    = 8;
  localparam int BITVBNK    = 3;
  localparam int NUMSROW    = 256;
  localparam int BITSROW    = 8;
  localparam int PHYWDTH    = 128;
  localparam int NUMGRPW    = 14;
  localparam int SRAM_DELAY = 2;

  logic                               clk;
  logic                               rst;
  logic [NUMGRPW*NUMVBNK-1:0]         t1_writeA;
  logic [NUMGRPW*NUMVBNK*BITSROW-1:0] t1_addrA;
  logic [NUMVBNK*PHYWDTH-1:0]         t1_bwA;
  logic [NUMVBNK*PHYWDTH-1:0]         t1_dinA;
  logic [NUMGRPW*NUMVBNK-1:0]         t1_readB;
  logic [NUMGRPW*NUMVBNK*BITSROW-1:0] t1_addrB;
  logic [NUMVBNK-1:0]                 inj_serr;
  logic [NUMVBNK*PHYWDTH-1:0]         t1_doutB;
  logic [NUMVBNK-1:0]                 t1_serrB;
  logic                               ready;
  logic                               grp_err;
  logic                               oor_err;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [PHYWDTH-1:0] ALL1 = {PHYWDTH{1'b1}};

  mrpnwp_t1_bank_resp #(
    .NUMVBNK    (NUMVBNK),
    .BITVBNK    (BITVBNK),
    .NUMSROW    (NUMSROW),
    .BITSROW    (BITSROW),
    .PHYWDTH    (PHYWDTH),
    .NUMGRPW    (NUMGRPW),
    .SRAM_DELAY (SRAM_DELAY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .t1_writeA (t1_writeA),
    .t1_addrA  (t1_addrA),
    .t1_bwA    (t1_bwA),
    .t1_dinA   (t1_dinA),
    .t1_readB  (t1_readB),
    .t1_addrB  (t1_addrB),
    .inj_serr  (inj_serr),
    .t1_doutB  (t1_doutB),
    .t1_serrB  (t1_serrB),
    .ready     (ready),
    .grp_err   (grp_err),
    .oor_err   (oor_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PHYWDTH-1:0] got, input logic [PHYWDTH-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PHYWDTH-1:0] dout_of(input int b);
    return t1_doutB[b*PHYWDTH +: PHYWDTH];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cmd();
    t1_writeA = '0;
    t1_addrA  = '0;
    t1_bwA    = '0;
    t1_dinA   = '0;
    t1_readB  = '0;
    t1_addrB  = '0;
    inj_serr  = '0;
  endtask

  task automatic set_wr(input int b, input int row, input logic [PHYWDTH-1:0] d, input logic [PHYWDTH-1:0] m);
    for (int g = 0; g < NUMGRPW; g++) begin
      t1_writeA[g*NUMVBNK+b] = 1'b1;
      t1_addrA[(g*NUMVBNK+b)*BITSROW +: BITSROW] = BITSROW'(row);
    end
    t1_dinA[b*PHYWDTH +: PHYWDTH] = d;
    t1_bwA[b*PHYWDTH +: PHYWDTH]  = m;
  endtask

  task automatic set_rd(input int b, input int row, input logic inj);
    for (int g = 0; g < NUMGRPW; g++) begin
      t1_readB[g*NUMVBNK+b] = 1'b1;
      t1_addrB[(g*NUMVBNK+b)*BITSROW +: BITSROW] = BITSROW'(row);
    end
    inj_serr[b] = inj;
  endtask

  task automatic do_write(input int b, input int row, input logic [PHYWDTH-1:0] d, input logic [PHYWDTH-1:0] m);
    clr_cmd();
    set_wr(b, row, d, m);
    cyc();
    clr_cmd();
  endtask

  // Issue a read and advance to the cycle its data is due (SRAM_DELAY = 2).
  task automatic do_read(input int b, input int row, input logic inj);
    clr_cmd();
    set_rd(b, row, inj);
    cyc();
    clr_cmd();
    cyc();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 400) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    clr_cmd();
    repeat (3) cyc();

    check("rst_ready", 128'(ready), 128'd0);
    check("rst_grp_err", 128'(grp_err), 128'd0);
    check("rst_oor_err", 128'(oor_err), 128'd0);
    check("rst_dout_any", 128'(|t1_doutB), 128'd0);

    rst = 1'b1;
    wait_ready(n);
    check("init_cycles", 128'(n), 128'(NUMSROW));

    do_read(5, 200, 1'b0);
    check("clr_b5_r200", dout_of(5), 128'd0);
    check("clr_b5_serr", 128'(t1_serrB[5]), 128'd0);

    do_write(2, 7, ALL1, 128'hFF);
    clr_cmd();
    set_rd(2, 7, 1'b0);
    cyc();
    clr_cmd();
    check("lat_b2_early", dout_of(2), 128'd0);
    cyc();
    check("mask_b2_r7", dout_of(2), 128'hFF);

    do_write(0, 9, 128'h3C, ALL1);
    clr_cmd();
    set_wr(0, 9, 128'hA5, ALL1);
    set_rd(0, 9, 1'b0);
    cyc();
    clr_cmd();
    set_rd(0, 9, 1'b0);
    cyc();
    clr_cmd();
    check("rbw_old", dout_of(0), 128'h3C);
    cyc();
    check("rbw_new", dout_of(0), 128'hA5);

    do_write(3, 4, 128'h10, ALL1);
    do_read(3, 4, 1'b1);
    check("inj_data", dout_of(3), 128'h11);
    check("inj_serr", 128'(t1_serrB[3]), 128'd1);
    cyc();
    check("inj_serr_pulse", 128'(t1_serrB[3]), 128'd0);
    check("inj_dout_hold", dout_of(3), 128'h11);
    do_read(3, 4, 1'b0);
    check("inj_stored", dout_of(3), 128'h10);
    check("inj_reread_serr", 128'(t1_serrB[3]), 128'd0);

    do_write(1, 11, 128'h77, ALL1);
    do_write(1, 12, 128'h88, ALL1);
    clr_cmd();
    set_rd(1, 11, 1'b0);
    t1_addrB[(4*NUMVBNK+1)*BITSROW +: BITSROW] = 8'd12;
    cyc();
    clr_cmd();
    check("grp_err_set", 128'(grp_err), 128'd1);
    cyc();
    check("grp_copy0_data", dout_of(1), 128'h77);
    check("grp_err_sticky", 128'(grp_err), 128'd1);
    check("oor_err_clear", 128'(oor_err), 128'd0);

    clr_cmd();
    set_rd(2, 7, 1'b0);
    repeat (4) cyc();
    check("burst_data", dout_of(2), 128'hFF);
    rst = 1'b0;
    cyc();
    check("mid_rst_ready", 128'(ready), 128'd0);
    check("mid_rst_grp_err", 128'(grp_err), 128'd0);
    check("mid_rst_dout", dout_of(2), 128'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("flush_dout", dout_of(2), 128'd0);
    end
    clr_cmd();
    wait_ready(n);
    check("reinit_cycles", 128'(n), 128'(NUMSROW - 3));

    do_read(2, 7, 1'b0);
    check("reinit_b2_r7", dout_of(2), 128'd0);
    do_read(0, 9, 1'b0);
    check("reinit_b0_r9", dout_of(0), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
